// File: rtl/risc_pkg.sv
// Shared ISA constants and fetch-FSM state type for the 16-bit RISC core.
package risc_pkg;

    localparam logic [3:0] OP_LW       = 4'b0000;
    localparam logic [3:0] OP_SW       = 4'b0001;
    localparam logic [3:0] OP_DP_FIRST = 4'b0010;
    localparam logic [3:0] OP_DP_LAST  = 4'b1001;
    localparam logic [3:0] OP_BEQ      = 4'b1011;
    localparam logic [3:0] OP_BNE      = 4'b1100;
    localparam logic [3:0] OP_J        = 4'b1101;

    localparam int OPC_HI   = 15;
    localparam int OPC_LO   = 12;
    localparam int J_OFF_W  = 12;
    localparam int BR_OFF_W = 6;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, jump-in-region, or PC-relative branch.
module next_pc_calc
    import risc_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [15:0]       ir,
    input  logic              jump,
    input  logic              beq,
    input  logic              bne,
    input  logic              zero,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] pc_plus2;
    logic [ADDR_W-1:0] br_off;
    logic              take_branch;
    logic              unused_opc;

    assign pc_plus2    = pc + ADDR_W'(2);
    // Word offset sign-extended and scaled to bytes
    assign br_off      = {{(ADDR_W-BR_OFF_W-1){ir[BR_OFF_W-1]}}, ir[BR_OFF_W-1:0], 1'b0};
    assign take_branch = (beq & zero) | (bne & ~zero);
    assign unused_opc  = ^ir[OPC_HI:OPC_LO];

    always_comb begin
        next_pc = pc_plus2;
        if (jump) begin
            next_pc = {pc_plus2[ADDR_W-1:J_OFF_W+1], ir[J_OFF_W-1:0], 1'b0};
        end else if (take_branch) begin
            next_pc = pc_plus2 + br_off;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: holds the PC, fetches one instruction over req/gnt/rvalid,
// presents it to decode and advances the PC at the retire handshake.
module instr_fetch_unit
    import risc_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [15:0]       imem_rdata,
    output logic              instr_valid,
    output logic [15:0]       instr,
    output logic [3:0]        instr_opcode,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              jump,
    input  logic              beq,
    input  logic              bne,
    input  logic              zero,
    output logic [15:0]       retired_count
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [15:0]       retired_count_q, retired_count_d;
    logic [ADDR_W-1:0] next_pc;

    next_pc_calc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc (
        .pc      (pc_q),
        .ir      (ir_q),
        .jump    (jump),
        .beq     (beq),
        .bne     (bne),
        .zero    (zero),
        .next_pc (next_pc)
    );

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        instr_pc_d      = instr_pc_q;
        ir_d            = ir_q;
        retired_count_d = retired_count_q;
        case (state_q)
            ST_REQ: begin
                if (imem_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    ir_d       = imem_rdata;
                    instr_pc_d = pc_q;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    pc_d            = next_pc & ~ADDR_W'(1);
                    retired_count_d = retired_count_q + 16'd1;
                    state_d         = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_REQ;
            pc_q            <= RESET_PC;
            instr_pc_q      <= RESET_PC;
            ir_q            <= 16'h0000;
            retired_count_q <= 16'h0000;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            instr_pc_q      <= instr_pc_d;
            ir_q            <= ir_d;
            retired_count_q <= retired_count_d;
        end
    end

    // The reset state is REQ, so the request is masked while rst is held
    assign imem_req      = (state_q == ST_REQ) & ~rst;
    assign imem_addr     = pc_q;
    assign instr_valid   = (state_q == ST_HOLD);
    assign instr         = ir_q;
    assign instr_opcode  = ir_q[OPC_HI:OPC_LO];
    assign instr_pc      = instr_pc_q;
    assign retired_count = retired_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, reset corner
// cases and randomized handshakes checked against an arithmetic next-PC model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [3:0]  instr_opcode;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic        jump;
    logic        beq;
    logic        bne;
    logic        zero;
    logic [15:0] retired_count;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] ref_pc;
    logic [15:0] ref_count;
    logic [15:0] mem [0:32767];

    typedef struct {
        logic [15:0] pc;
        logic [15:0] ir;
        logic        j;
        logic        bq;
        logic        bn;
        logic        z;
        int          gnt_dly;
        int          rv_dly;
        int          rdy_dly;
        logic [15:0] next_pc;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    instr_fetch_unit #(
        .ADDR_W   (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_opcode  (instr_opcode),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .jump          (jump),
        .beq           (beq),
        .bne           (bne),
        .zero          (zero),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [15:0] b16(input logic b);
        return {15'b0, b};
    endfunction

    // Next PC straight from the ISA rules using integer arithmetic
    function automatic logic [15:0] modelNextPc(input logic [15:0] pc, input logic [15:0] ir,
                                                input logic j, input logic bq,
                                                input logic bn, input logic z);
        int p2, off, tgt;
        p2 = (int'(pc) + 2) % 65536;
        if (j) begin
            tgt = (p2 / 8192) * 8192 + int'(ir % 16'd4096) * 2;
        end else begin
            off = int'(ir % 16'd64);
            if (off >= 32) off = off - 64;
            if ((bq && z) || (bn && !z)) tgt = (p2 + 2 * off + 65536) % 65536;
            else tgt = p2;
        end
        return 16'(tgt);
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full fetch/retire transaction starting in REQ
    task automatic applyStimulus(input int gnt_dly, input int rv_dly, input int rdy_dly,
                                 input logic j, input logic bq, input logic bn,
                                 input logic z, input logic spurious);
        logic [15:0] exp_ir;
        logic [15:0] held_addr;
        checkOutput("req_high", b16(imem_req), 16'd1);
        checkOutput("fetch_addr", imem_addr, ref_pc);
        checkOutput("valid_low", b16(instr_valid), 16'd0);
        checkOutput("retired", retired_count, ref_count);
        held_addr = imem_addr;
        for (int k = 0; k < gnt_dly; k++) begin
            imem_gnt    = 1'b0;
            imem_rvalid = spurious;
            imem_rdata  = 16'hBAD0 ^ 16'(k);
            instr_ready = 1'($urandom);
            tick();
            checkOutput("req_stall", b16(imem_req), 16'd1);
            checkOutput("addr_stall", imem_addr, held_addr);
            checkOutput("valid_stall", b16(instr_valid), 16'd0);
            checkOutput("retired_stall", retired_count, ref_count);
        end
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        imem_gnt    = 1'b1;
        tick();
        imem_gnt = 1'b0;
        checkOutput("req_wait", b16(imem_req), 16'd0);
        checkOutput("valid_wait", b16(instr_valid), 16'd0);
        for (int k = 0; k < rv_dly; k++) begin
            instr_ready = 1'($urandom);
            tick();
            checkOutput("req_wait_stall", b16(imem_req), 16'd0);
            checkOutput("valid_wait_stall", b16(instr_valid), 16'd0);
        end
        exp_ir      = mem[ref_pc[15:1]];
        instr_ready = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = exp_ir;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 16'($urandom);
        checkOutput("valid_hold", b16(instr_valid), 16'd1);
        checkOutput("instr", instr, exp_ir);
        checkOutput("opcode", {12'b0, instr_opcode}, {12'b0, exp_ir[15:12]});
        checkOutput("instr_pc", instr_pc, ref_pc);
        for (int k = 0; k < rdy_dly; k++) begin
            jump = 1'($urandom);
            beq  = 1'($urandom);
            bne  = 1'($urandom);
            zero = 1'($urandom);
            tick();
            checkOutput("valid_hold_stall", b16(instr_valid), 16'd1);
            checkOutput("instr_stable", instr, exp_ir);
            checkOutput("opcode_stable", {12'b0, instr_opcode}, {12'b0, exp_ir[15:12]});
            checkOutput("retired_hold", retired_count, ref_count);
        end
        jump        = j;
        beq         = bq;
        bne         = bn;
        zero        = z;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        jump        = 1'b0;
        beq         = 1'b0;
        bne         = 1'b0;
        zero        = 1'b0;
        ref_pc      = modelNextPc(ref_pc, exp_ir, j, bq, bn, z);
        ref_count   = ref_count + 16'd1;
    endtask

    initial begin
        vecs[0]  = '{16'h0000, 16'hB03E, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 0, 16'hFFFE};
        vecs[1]  = '{16'hFFFE, 16'h3456, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 16'h0000};
        vecs[2]  = '{16'h0000, 16'hD010, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 16'h0020};
        vecs[3]  = '{16'h0020, 16'hB03E, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 16'h0022};
        vecs[4]  = '{16'h0022, 16'hC03E, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 16'h0020};
        vecs[5]  = '{16'h0020, 16'hB03E, 1'b0, 1'b1, 1'b0, 1'b1, 5, 6, 4, 16'h001E};
        vecs[6]  = '{16'h001E, 16'hD010, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 16'h0020};
        vecs[7]  = '{16'h0020, 16'hC03E, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 16'h001E};
        vecs[8]  = '{16'h001E, 16'hDFFF, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 16'h1FFE};
        vecs[9]  = '{16'h1FFE, 16'hDFFF, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 16'h3FFE};
        vecs[10] = '{16'h3FFE, 16'hD008, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 16'h4010};
        vecs[11] = '{16'h4010, 16'hD123, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 16'h4246};
        vecs[12] = '{16'h4246, 16'hB001, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 0, 16'h424A};
        vecs[13] = '{16'h424A, 16'hD000, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 0, 16'h4000};
        vecs[14] = '{16'h4000, 16'hC01F, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 16'h4040};
        vecs[15] = '{16'h4040, 16'hB020, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 16'h4042};
        vecs[16] = '{16'h4042, 16'hB020, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 0, 16'h4004};

        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);

        rst         = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0000;
        instr_ready = 1'b0;
        jump        = 1'b0;
        beq         = 1'b0;
        bne         = 1'b0;
        zero        = 1'b0;
        tick();
        tick();
        checkOutput("rst_req", b16(imem_req), 16'd0);
        checkOutput("rst_valid", b16(instr_valid), 16'd0);
        checkOutput("rst_addr", imem_addr, 16'h0000);
        checkOutput("rst_instr", instr, 16'h0000);
        checkOutput("rst_retired", retired_count, 16'h0000);
        rst = 1'b0;
        #1;
        ref_pc    = 16'h0000;
        ref_count = 16'h0000;

        for (int i = 0; i < 4; i++) begin
            mem[i] = 16'h2000 | 16'(i);
            applyStimulus(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("seq_addr8", imem_addr, 16'h0008);
        checkOutput("seq_count4", retired_count, 16'd4);

        // Reset asynchronously while waiting for read data at pc 8
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        checkOutput("mid_wait_req", b16(imem_req), 16'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_valid", b16(instr_valid), 16'd0);
        checkOutput("async_req", b16(imem_req), 16'd0);
        checkOutput("async_addr", imem_addr, 16'h0000);
        checkOutput("async_retired", retired_count, 16'h0000);
        tick();
        rst = 1'b0;
        #1;
        ref_pc    = 16'h0000;
        ref_count = 16'h0000;
        checkOutput("post_rst_req", b16(imem_req), 16'd1);
        checkOutput("post_rst_addr", imem_addr, 16'h0000);
        imem_rvalid = 1'b1;
        imem_rdata  = 16'hDEAD;
        tick();
        imem_rvalid = 1'b0;
        checkOutput("stale_instr", instr, 16'h0000);
        checkOutput("stale_valid", b16(instr_valid), 16'd0);

        for (int i = 0; i < NV; i++) begin
            checkOutput("tbl_pc", imem_addr, vecs[i].pc);
            mem[vecs[i].pc[15:1]] = vecs[i].ir;
            applyStimulus(vecs[i].gnt_dly, vecs[i].rv_dly, vecs[i].rdy_dly,
                          vecs[i].j, vecs[i].bq, vecs[i].bn, vecs[i].z,
                          vecs[i].gnt_dly > 0);
            checkOutput("tbl_next", imem_addr, vecs[i].next_pc);
        end

        for (int i = 0; i < 150; i++) begin
            applyStimulus($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                          ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom));
        end
        checkOutput("final_addr", imem_addr, ref_pc);
        checkOutput("final_retired", retired_count, ref_count);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
